// File: rtl/znc_branch_unit.sv
// znc_branch_unit: ZNC status register, BR/JR evaluation, PC ownership and post-redirect flush.
// Optional taken-branch counter enabled by defining ZNC_BRANCH_COUNT_EN.
module znc_branch_unit #(
   parameter logic [15:0] RESET_PC     = 16'h0000,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ins_valid,
   output logic        ins_ready,
   input  logic [15:0] ins,
   input  logic [15:0] ra,
   input  logic        flag_we,
   input  logic [2:0]  znc_in,
   output logic [2:0]  znc_q,
   output logic [15:0] pc,
   output logic        redirect,
   output logic        flushing,
   output logic [15:0] taken_cnt
);
   typedef enum logic {RUN, FLUSH} state_t;
   localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
   state_t      state_q;
   logic [3:0]  fcnt_q;
   logic [15:0] pc_q, pc_d, br_target;
   logic        redirect_q, accept, is_br, is_jr, cond_ok, taken;
   logic [2:0]  flags;
   assign ins_ready = (state_q == RUN);
   assign accept    = ins_valid && ins_ready;
   assign is_br     = (ins[15:12] == 4'hC);
   assign is_jr     = (ins[15:12] == 4'hD);
   // Same-cycle flag writes are forwarded so a compare can feed the very next branch.
   assign flags     = flag_we ? znc_in : znc_q;
   always_comb begin
      cond_ok = 1'b0;
      case (ins[11:8])
         4'd0: cond_ok = 1'b1;
         4'd1: cond_ok = flags[2];
         4'd2: cond_ok = !flags[2];
         4'd3: cond_ok = flags[1];
         4'd4: cond_ok = !flags[1];
         4'd5: cond_ok = flags[0];
         4'd6: cond_ok = !flags[0];
         4'd7: cond_ok = flags[2] | flags[1];
         4'd8: cond_ok = !flags[2] & !flags[1];
         default: cond_ok = 1'b0;
      endcase
   end
   assign taken     = accept && (is_jr || (is_br && cond_ok));
   assign br_target = pc_q + 16'd1 + {{8{ins[7]}}, ins[7:0]};
   assign pc_d      = !accept ? pc_q : is_jr ? ra : (is_br && cond_ok) ? br_target : pc_q + 16'd1;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         fcnt_q     <= '0;
         pc_q       <= RESET_PC;
         znc_q      <= '0;
         redirect_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         redirect_q <= taken;
         if (flag_we) znc_q <= znc_in;
         case (state_q)
            RUN: if (taken) begin
               state_q <= FLUSH;
               fcnt_q  <= FLUSH_LAST;
            end
            FLUSH: if (fcnt_q == 4'd0) state_q <= RUN;
                   else fcnt_q <= fcnt_q - 4'd1;
            default: state_q <= RUN;
         endcase
      end
   end
   assign pc       = pc_q;
   assign redirect = redirect_q;
   assign flushing = (state_q == FLUSH);
`ifdef ZNC_BRANCH_COUNT_EN
   logic [15:0] cnt_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else if (taken) cnt_q <= cnt_q + 16'd1;
   end
   assign taken_cnt = cnt_q;
`else
   assign taken_cnt = 16'h0000;
`endif
endmodule

// File: doc/znc_branch_unit.md
Name: znc_branch_unit

Overview:
- Consumer end of the 3-bit ZNC flag interface, which carries the output of the flag/compare unit.
- Latches ZNC into the architectural status register.
- Evaluates conditional-branch and jump-register instructions against those flags.
- Owns the 16-bit PC, driving redirects and a fixed-length flush to the fetch stage through a valid/ready instruction handshake.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, bubble cycles after a taken branch/jump; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ins_valid  input  1  fetch presents an instruction.
- ins_ready  output  1  unit accepts the instruction this cycle.
- ins  input  16  instruction word.
- ra  input  16  register A value; jump target for JR.
- flag_we  input  1  load znc_in into the status register.
- znc_in  input  3  flags from the flag unit; [2]=Z, [1]=N, [0]=C.
- znc_q  output  3  registered status flags.
- pc  output  16  current PC.
- redirect  output  1  one-cycle pulse when pc was loaded non-sequentially.
- flushing  output  1  high while in FLUSH.
- taken_cnt  output  16  taken-branch counter (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, znc_q=3'b000.
  - State=RUN, redirect=0, flushing=0, taken_cnt=0.
  - ins_ready=1 from the first cycle after rst_n deasserts.
- Reset mid-FLUSH aborts the flush; no pending redirect survives.
- Accept: ins_valid && ins_ready on a rising edge. ins_ready = (state==RUN), combinational from state only.
- Decode (ins[15:12]):
  - 4'hC = BR: cond=ins[11:8], off=ins[7:0] signed.
  - 4'hD = JR: target=ra.
  - All other opcodes are non-control: pc <= pc+1.
- BR cond codes:
  - 0 always
  - 1 Z, 2 !Z
  - 3 N, 4 !N
  - 5 C, 6 !C
  - 7 Z|N
  - 8 !Z&!N
  - 9..15 never taken
- Flag source for evaluation:
  - Normally znc_q.
  - If flag_we=1 in the same cycle as the accept, use znc_in (forwarding).
- Not-taken BR: pc <= pc+1.
- Taken BR: pc <= pc + 1 + sext(off), modulo 2^16 (wrap-around silent; 16'hFFFF+1 = 16'h0000).
- JR: always taken; pc <= ra.
- On a taken accept:
  - The next cycle shows the new pc, redirect=1, state=FLUSH, flushing=1.
  - FLUSH holds for FLUSH_CYCLES cycles with ins_ready=0, then returns to RUN.
  - ins_valid during FLUSH is ignored (not accepted, no pc change).
- flag_we is independent of the handshake: znc_q <= znc_in on any edge with flag_we=1, including during FLUSH and with no accept.
- redirect is high exactly one cycle per taken event; never asserted in RUN without a preceding taken accept.
- No accept in a cycle: pc holds.

Optional Feature:
- Macro: ZNC_BRANCH_COUNT_EN.
- Defined:
  - taken_cnt increments by 1 on every taken BR/JR accept.
  - Wraps 16'hFFFF -> 16'h0000.
  - Reset to 0.
- Undefined: counter logic absent; taken_cnt tied to 16'h0000. Port list unchanged.

Test Plan:
1. Reset with RESET_PC=16'h0100, then 3 accepted non-control instructions (ins=16'h1000) -> pc 0x0101, 0x0102, 0x0103; redirect=0 throughout; znc_q=000.
2. flag_we=1, znc_in=3'b100, then BR Z off=+4 (ins=16'hC104) at pc=0x0010:
   - pc=0x0015, redirect pulses 1 cycle.
   - ins_ready low for exactly 2 cycles; ins_valid during that window leaves pc unchanged.
3. znc_q=000, BR Z (16'hC1FE) -> not taken: pc+1, no flush. Same instruction with flag_we=1, znc_in=100 in the accept cycle -> taken via forwarding: pc = pc+1-2.
4. JR with ra=16'hBEEF -> pc=0xBEEF next cycle, redirect=1, flushing high FLUSH_CYCLES cycles. BR cond=9 (16'hC97F) -> never taken.
5. At pc=16'hFFF0, BR always off=+0x7F (16'hC07F) -> pc=16'h0070 (wrap). Assert rst_n=0 during the resulting FLUSH -> immediate pc=RESET_PC, flushing=0, ins_ready=1 after release.
6. With ZNC_BRANCH_COUNT_EN, 3 taken and 2 not-taken branches -> taken_cnt=3. Without the macro -> taken_cnt=0.
